ppu_vec: RTL

- Multi-lane, parametrised post-processing unit placed after the PE array accumulators.
- Each lane takes one IN_BITS accumulator word and applies, in order:
  - post-quantisation: arithmetic right shift with round-half-up and saturation to signed OUT_BITS;
  - optional ReLU;
  - optional max-pool across a window of beats.
- Adds valid/ready streaming, back-pressure, lane parallelism and windowed pooling with a saturation flag.

---
 rtl/ppu_pkg.sv | 34 +++
 rtl/ppu_quant_lane.sv | 55 +++++
 rtl/ppu_vec.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared types and constants for the post-processing unit.
//   - Default widths for lanes, accumulator input, quantised output and shift.
//   - Signed saturation bounds for an OUT_BITS result (as helper functions and
//     as constants at the default width).
//   - Per-beat configuration bundle (shift amount, ReLU enable, pool enable).
package ppu_pkg;

  localparam int PPU_LANES    = 4;
  localparam int PPU_IN_BITS  = 32;
  localparam int PPU_OUT_BITS = 8;
  localparam int PPU_SF_BITS  = 6;

  // Largest / smallest value representable in a signed field of 'bits' bits.
  function automatic int out_max(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int out_min(input int bits);
    return -(1 << (bits - 1));
  endfunction

  localparam int PPU_OUT_MAX = out_max(PPU_OUT_BITS);
  localparam int PPU_OUT_MIN = out_min(PPU_OUT_BITS);

  typedef logic signed [PPU_IN_BITS-1:0]  lane_in_t;
  typedef logic signed [PPU_OUT_BITS-1:0] lane_out_t;

  typedef struct packed {
    logic [PPU_SF_BITS-1:0] scaling_factor;
    logic                   relu_en;
    logic                   maxpool_en;
  } ppu_cfg_t;

endpackage

// File: rtl/ppu_quant_lane.sv
// Combinational quantiser for one lane.
//   lane_i     : signed IN_BITS accumulator word
//   sf_i       : right-shift amount (clamped to IN_BITS-1)
//   relu_en_i  : clamp negative results to zero
//   res_o      : signed OUT_BITS result
//   sat_o      : result was clipped to the OUT_BITS range (ReLU does not affect it)
module ppu_quant_lane
  import ppu_pkg::*;
#(
  parameter int IN_BITS  = PPU_IN_BITS,
  parameter int OUT_BITS = PPU_OUT_BITS,
  parameter int SF_BITS  = PPU_SF_BITS
) (
  input  logic signed [IN_BITS-1:0]  lane_i,
  input  logic        [SF_BITS-1:0]  sf_i,
  input  logic                       relu_en_i,
  output logic signed [OUT_BITS-1:0] res_o,
  output logic                       sat_o
);

  localparam logic        [SF_BITS-1:0]  S_MAX = SF_BITS'(IN_BITS - 1);
  localparam logic signed [IN_BITS:0]    R_MAX = (IN_BITS+1)'(out_max(OUT_BITS));
  localparam logic signed [IN_BITS:0]    R_MIN = (IN_BITS+1)'(out_min(OUT_BITS));
  localparam logic signed [OUT_BITS-1:0] O_MAX = OUT_BITS'(out_max(OUT_BITS));
  localparam logic signed [OUT_BITS-1:0] O_MIN = OUT_BITS'(out_min(OUT_BITS));

  logic        [SF_BITS-1:0]  s;
  logic signed [IN_BITS:0]    vx;
  logic signed [IN_BITS:0]    rnd;
  logic signed [IN_BITS:0]    r;
  logic signed [OUT_BITS-1:0] q;

  always_comb begin
    s   = (sf_i > S_MAX) ? S_MAX : sf_i;
    // One guard bit so that adding the half-LSB cannot wrap a large positive word.
    vx  = {lane_i[IN_BITS-1], lane_i};
    rnd = '0;
    if (s != '0) begin
      rnd = (IN_BITS+1)'(1) << (s - 1'b1);
    end
    // Arithmetic shift floors, so adding half an LSB first rounds half toward +inf.
    r     = (vx + rnd) >>> s;
    q     = r[OUT_BITS-1:0];
    sat_o = 1'b0;
    if (r > R_MAX) begin
      q     = O_MAX;
      sat_o = 1'b1;
    end else if (r < R_MIN) begin
      q     = O_MIN;
      sat_o = 1'b1;
    end
    res_o = (relu_en_i && q[OUT_BITS-1]) ? '0 : q;
  end

endmodule

// File: rtl/ppu_vec.sv
// Multi-lane post-processing unit: quantise (+ReLU) each lane, then optionally
// max-pool across a window of beats closed by in_last.
//   clk, rst          : clock, synchronous active-low reset
//   in_valid/in_ready : input handshake; in_data packs LANES signed words
//   in_last           : closes the current pooling window
//   scaling_factor, relu_en, maxpool_en : per-beat configuration
//   out_valid/out_ready : output handshake; out_data packs LANES signed results
//   out_sat           : some lane saturated in a beat contributing to this output
// Two stages: S1 holds quantised lanes, S2 is the pool accumulator / output.
module ppu_vec
  import ppu_pkg::*;
#(
  parameter int LANES    = PPU_LANES,
  parameter int IN_BITS  = PPU_IN_BITS,
  parameter int OUT_BITS = PPU_OUT_BITS,
  parameter int SF_BITS  = PPU_SF_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*IN_BITS-1:0]  in_data,
  input  logic                      in_last,
  input  logic [SF_BITS-1:0]        scaling_factor,
  input  logic                      relu_en,
  input  logic                      maxpool_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_BITS-1:0] out_data,
  output logic                      out_sat
);

  ppu_cfg_t cfg;
  logic     adv;
  logic     accept;
  logic     pool_eff;

  logic [LANES*OUT_BITS-1:0] q_data;
  logic [LANES-1:0]          q_sat;
  logic [LANES*OUT_BITS-1:0] pool_max;

  // Window tracking on the input side.
  logic win_open_q, win_open_d;

  // S1 registers.
  logic                      s1_valid_q, s1_valid_d;
  logic [LANES*OUT_BITS-1:0] s1_data_q, s1_data_d;
  logic [LANES-1:0]          s1_sat_q, s1_sat_d;
  logic                      s1_pool_q, s1_pool_d;
  logic                      s1_first_q, s1_first_d;
  logic                      s1_last_q, s1_last_d;

  // S2 registers: running max doubles as the output word.
  logic                      out_valid_q, out_valid_d;
  logic [LANES*OUT_BITS-1:0] acc_q, acc_d;
  logic                      sat_acc_q, sat_acc_d;

  assign cfg.scaling_factor = PPU_SF_BITS'(scaling_factor);
  assign cfg.relu_en        = relu_en;
  assign cfg.maxpool_en     = maxpool_en;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = rst && adv;
  assign accept   = in_valid && in_ready;

  // A window only opens in pool mode, so an open window implies pooling and
  // mid-window changes of maxpool_en are ignored without a separate latch.
  assign pool_eff = win_open_q || cfg.maxpool_en;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [OUT_BITS-1:0] cur;
      logic signed [OUT_BITS-1:0] nxt;

      ppu_quant_lane #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .SF_BITS  (PPU_SF_BITS)
      ) u_quant (
        .lane_i    (in_data[gi*IN_BITS +: IN_BITS]),
        .sf_i      (cfg.scaling_factor),
        .relu_en_i (cfg.relu_en),
        .res_o     (q_data[gi*OUT_BITS +: OUT_BITS]),
        .sat_o     (q_sat[gi])
      );

      assign cur = acc_q[gi*OUT_BITS +: OUT_BITS];
      assign nxt = s1_data_q[gi*OUT_BITS +: OUT_BITS];
      // Strict compare: ties keep the earlier (identical) value.
      assign pool_max[gi*OUT_BITS +: OUT_BITS] = (nxt > cur) ? nxt : cur;
    end
  endgenerate

  always_comb begin
    win_open_d = win_open_q;
    if (accept && pool_eff) begin
      win_open_d = !in_last;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_sat_d   = s1_sat_q;
    s1_pool_d  = s1_pool_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    if (adv) begin
      s1_valid_d = accept;
      s1_data_d  = q_data;
      s1_sat_d   = q_sat;
      s1_pool_d  = pool_eff;
      s1_first_d = !win_open_q;
      s1_last_d  = in_last;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    sat_acc_d   = sat_acc_q;
    if (adv) begin
      out_valid_d = 1'b0;
      if (s1_valid_q) begin
        if (!s1_pool_q || s1_first_q) begin
          acc_d     = s1_data_q;
          sat_acc_d = |s1_sat_q;
        end else begin
          acc_d     = pool_max;
          sat_acc_d = sat_acc_q || (|s1_sat_q);
        end
        out_valid_d = !s1_pool_q || s1_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      win_open_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_sat_q    <= '0;
      s1_pool_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      sat_acc_q   <= 1'b0;
    end else begin
      win_open_q  <= win_open_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_sat_q    <= s1_sat_d;
      s1_pool_q   <= s1_pool_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      sat_acc_q   <= sat_acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_sat   = sat_acc_q;

endmodule
